// File: rtl/inst_fetch_pkg.sv
// Shared core constants for the fetch stage: canonical NOP, opcodes,
// default reset PC and the B-type immediate pre-decode helper.
package inst_fetch_pkg;

   localparam logic [31:0] NOP_INST     = 32'h0000_0013;
   localparam logic [6:0]  OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0]  OPC_JAL      = 7'b1101111;
   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

   function automatic logic [31:0] b_imm(input logic [31:0] inst);
      return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   endfunction

endpackage

// File: rtl/branch_history_table.sv
// 2-bit saturating-counter branch history table: combinational read,
// one synchronous update port, every entry resets to weakly not-taken.
module branch_history_table
   import inst_fetch_pkg::*;
#(
   parameter int BHT_IDX_W = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [BHT_IDX_W-1:0] rd_idx,
   output logic [1:0]           rd_cnt,
   input  logic                 upd,
   input  logic [BHT_IDX_W-1:0] upd_idx,
   input  logic                 upd_taken
);

   localparam int N_ENT = 1 << BHT_IDX_W;

   logic [1:0] cnt [N_ENT];

   // read sees the pre-edge value when the same entry is being updated
   assign rd_cnt = cnt[rd_idx];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N_ENT; i++) cnt[i] <= 2'b01;
      end else if (upd) begin
         if (upd_taken && (cnt[upd_idx] != 2'b11))
            cnt[upd_idx] <= cnt[upd_idx] + 2'd1;
         else if (!upd_taken && (cnt[upd_idx] != 2'b00))
            cnt[upd_idx] <= cnt[upd_idx] - 2'd1;
      end
   end

endmodule

// File: rtl/inst_fetch.sv
// RV32I instruction-fetch stage: PC register, branch pre-decode and
// prediction, next-PC selection and the IF/ID pipeline register.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
   parameter int          BHT_IDX_W = 6
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr_o,
   input  logic [31:0] imem_data_i,
   input  logic        stall_i,
   input  logic        branch_i,
   input  logic [31:0] pc_branch_i,
   input  logic        jmp_i,
   input  logic [31:0] pc_jmp_i,
   input  logic        bht_upd_i,
   input  logic [31:0] bht_upd_pc_i,
   input  logic        bht_taken_i,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o,
   output logic        branch_pred_o
);

   logic [31:0] pc_q;
   logic [31:0] pc_nxt;
   logic [31:0] pred_tgt;
   logic        is_br;
   logic        pred_taken;
   logic        redirect;
   logic [1:0]  bht_cnt;
   logic        unused_upd_pc;

   // only the index bits of the update PC address the table
   assign unused_upd_pc = ^{bht_upd_pc_i[31:BHT_IDX_W+2], bht_upd_pc_i[1:0]};

   branch_history_table #(
      .BHT_IDX_W (BHT_IDX_W)
   ) u_bht (
      .clk       (clk),
      .rst       (rst),
      .rd_idx    (pc_q[BHT_IDX_W+1:2]),
      .rd_cnt    (bht_cnt),
      .upd       (bht_upd_i),
      .upd_idx   (bht_upd_pc_i[BHT_IDX_W+1:2]),
      .upd_taken (bht_taken_i)
   );

   assign imem_addr_o = pc_q;
   assign redirect    = branch_i | jmp_i;

   always_comb begin
      is_br      = (imem_data_i[6:0] == OPC_BRANCH);
      pred_taken = is_br & bht_cnt[1];
      pred_tgt   = pc_q + b_imm(imem_data_i);
      pc_nxt     = pc_q + 32'd4;
      if (branch_i)        pc_nxt = pc_branch_i;
      else if (jmp_i)      pc_nxt = pc_jmp_i;
      else if (stall_i)    pc_nxt = pc_q;
      else if (pred_taken) pc_nxt = pred_tgt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_nxt;
      end
   end

   // a redirect flushes IF/ID even while decode is stalling
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_o          <= 32'h0;
         inst_o        <= NOP_INST;
         branch_pred_o <= 1'b0;
      end else if (redirect) begin
         pc_o          <= 32'h0;
         inst_o        <= NOP_INST;
         branch_pred_o <= 1'b0;
      end else if (!stall_i) begin
         pc_o          <= pc_q;
         inst_o        <= imem_data_i;
         branch_pred_o <= pred_taken;
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed reset/stall/predict/redirect/saturation
// sequences, a redirect vector table, then random traffic against a model.
module tb_inst_fetch;
   import inst_fetch_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] imem_addr, imem_data;
   logic        stall = 1'b0, br = 1'b0, jmp = 1'b0, upd = 1'b0, taken = 1'b0;
   logic [31:0] pcb = '0, pcj = '0, upd_pc = '0;
   logic [31:0] pc_o, inst_o;
   logic        pred_o;

   logic [31:0] imem [256];
   assign imem_data = imem[imem_addr[9:2]];

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   inst_fetch #(.RESET_PC(32'h100), .BHT_IDX_W(6)) dut (
      .clk           (clk),
      .rst           (rst),
      .imem_addr_o   (imem_addr),
      .imem_data_i   (imem_data),
      .stall_i       (stall),
      .branch_i      (br),
      .pc_branch_i   (pcb),
      .jmp_i         (jmp),
      .pc_jmp_i      (pcj),
      .bht_upd_i     (upd),
      .bht_upd_pc_i  (upd_pc),
      .bht_taken_i   (taken),
      .pc_o          (pc_o),
      .inst_o        (inst_o),
      .branch_pred_o (pred_o)
   );

   typedef struct {
      logic        stall;
      logic        br;
      logic [31:0] pcb;
      logic        jmp;
      logic [31:0] pcj;
      logic [31:0] exp_addr;
      logic [31:0] exp_after;
   } redir_t;

   redir_t vec [5];

   // reference model state
   logic [31:0] m_pc, m_pco, m_inst;
   logic        m_pred;
   int          m_bht [64];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      stall = 1'b0; br = 1'b0; jmp = 1'b0; upd = 1'b0;
   endtask

   task automatic probe(input logic exp_taken, input string nm);
      jmp = 1'b1; pcj = 32'h200;
      tick();
      jmp = 1'b0;
      chk({nm, "_addr"}, imem_addr, 32'h200);
      tick();
      chk({nm, "_next"}, imem_addr, exp_taken ? 32'h210 : 32'h204);
      chk({nm, "_pred"}, 32'(pred_o), 32'(exp_taken));
   endtask

   task automatic upd_n(input int n, input logic t);
      upd = 1'b1; upd_pc = 32'h200; taken = t;
      repeat (n) tick();
      upd = 1'b0;
   endtask

   task automatic model_reset();
      m_pc = 32'h100; m_pco = 32'h0; m_inst = NOP_INST; m_pred = 1'b0;
      for (int i = 0; i < 64; i++) m_bht[i] = 1;
   endtask

   task automatic model_step();
      logic [31:0] w, imm, tgt;
      logic        ptk;
      int          ui;
      w   = imem[m_pc[9:2]];
      imm = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
      tgt = m_pc + imm;
      ptk = (w[6:0] == 7'b1100011) && (m_bht[m_pc[7:2]] >= 2);
      if (br || jmp) begin
         m_pco = 32'h0; m_inst = NOP_INST; m_pred = 1'b0;
      end else if (!stall) begin
         m_pco = m_pc; m_inst = w; m_pred = ptk;
      end
      if (br)         m_pc = pcb;
      else if (jmp)   m_pc = pcj;
      else if (stall) m_pc = m_pc;
      else if (ptk)   m_pc = tgt;
      else            m_pc = m_pc + 32'd4;
      if (upd) begin
         ui = int'(upd_pc[7:2]);
         if (taken) m_bht[ui] = (m_bht[ui] < 3) ? m_bht[ui] + 1 : 3;
         else       m_bht[ui] = (m_bht[ui] > 0) ? m_bht[ui] - 1 : 0;
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) imem[i] = 32'h0000_0013 | (32'(i) << 20);
      imem[8'h80] = 32'h0000_0863;  // BEQ x0,x0,+16 at 0x200

      vec[0] = '{1'b1, 1'b1, 32'h300, 1'b0, 32'h0,         32'h300,       32'h304};
      vec[1] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h80,        32'h80,        32'h84};
      vec[2] = '{1'b0, 1'b1, 32'h340, 1'b1, 32'h80,        32'h340,       32'h344};
      vec[3] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0};
      vec[4] = '{1'b0, 1'b1, 32'h200, 1'b0, 32'h0,         32'h200,       32'h210};

      // reset
      repeat (3) tick();
      chk("rst_addr", imem_addr, 32'h100);
      chk("rst_inst", inst_o, NOP_INST);
      chk("rst_pc_o", pc_o, 32'h0);
      chk("rst_pred", 32'(pred_o), 32'h0);
      rst = 1'b1;
      tick();
      chk("rel_pc_o0", pc_o, 32'h100);
      chk("rel_addr0", imem_addr, 32'h104);
      tick();
      chk("rel_pc_o1", pc_o, 32'h104);
      chk("rel_inst1", inst_o, imem[8'h41]);

      // stall for three cycles
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("stall_pc_o", pc_o, 32'h104);
         chk("stall_inst", inst_o, imem[8'h41]);
         chk("stall_addr", imem_addr, 32'h108);
      end
      stall = 1'b0;
      tick();
      chk("unstall_pc_o0", pc_o, 32'h108);
      chk("unstall_addr0", imem_addr, 32'h10C);
      tick();
      chk("unstall_pc_o1", pc_o, 32'h10C);

      // prediction with BHT entry at weakly not-taken
      jmp = 1'b1; pcj = 32'h200;
      tick();
      jmp = 1'b0;
      chk("jmp_bubble", inst_o, NOP_INST);
      chk("jmp_pc_o", pc_o, 32'h0);
      chk("jmp_addr", imem_addr, 32'h200);
      tick();
      chk("nt_addr", imem_addr, 32'h204);
      chk("nt_pc_o", pc_o, 32'h200);
      chk("nt_inst", inst_o, 32'h0000_0863);
      chk("nt_pred", 32'(pred_o), 32'h0);
      upd_n(2, 1'b1);
      probe(1'b1, "pt");

      // redirect vectors
      for (int v = 0; v < 5; v++) begin
         stall = vec[v].stall; br = vec[v].br; pcb = vec[v].pcb;
         jmp = vec[v].jmp; pcj = vec[v].pcj;
         tick();
         idle();
         chk($sformatf("vec%0d_addr", v), imem_addr, vec[v].exp_addr);
         chk($sformatf("vec%0d_inst", v), inst_o, NOP_INST);
         chk($sformatf("vec%0d_pred", v), 32'(pred_o), 32'h0);
         chk($sformatf("vec%0d_pc_o", v), pc_o, 32'h0);
         tick();
         chk($sformatf("vec%0d_pc_o2", v), pc_o, vec[v].exp_addr);
         chk($sformatf("vec%0d_after", v), imem_addr, vec[v].exp_after);
      end

      // BHT saturation and single-step movement (entry currently 11)
      upd_n(5, 1'b0);
      upd_n(1, 1'b1);
      probe(1'b0, "sat_lo");
      upd_n(1, 1'b1);
      probe(1'b1, "lo_step");
      upd_n(5, 1'b1);
      upd_n(1, 1'b0);
      probe(1'b1, "sat_hi");
      upd_n(1, 1'b0);
      probe(1'b0, "hi_step");
      upd = 1'b1; upd_pc = 32'h200;
      taken = 1'b1; tick();
      taken = 1'b0; tick();
      taken = 1'b1; tick();
      upd = 1'b0;
      probe(1'b1, "alt_a");
      upd = 1'b1;
      taken = 1'b0; tick();
      taken = 1'b1; tick();
      taken = 1'b0; tick();
      upd = 1'b0;
      probe(1'b0, "alt_b");

      // random traffic against the model, with one asynchronous reset mid-run
      rst = 1'b0;
      idle();
      for (int i = 0; i < 256; i++) begin
         logic [31:0] r;
         r = $urandom;
         r[6:0] = ($urandom_range(0, 2) == 0) ? 7'b1100011 : 7'b0010011;
         imem[i] = r;
      end
      tick();
      rst = 1'b1;
      model_reset();
      for (int k = 0; k < 400; k++) begin
         stall  = ($urandom_range(0, 4) == 0);
         br     = ($urandom_range(0, 19) == 0);
         jmp    = !br && ($urandom_range(0, 19) == 0);
         pcb    = $urandom & 32'hFFFF_FFFC;
         pcj    = $urandom & 32'hFFFF_FFFC;
         upd    = ($urandom_range(0, 1) == 1);
         upd_pc = ($urandom_range(0, 1) == 1) ? m_pc : $urandom;
         taken  = ($urandom_range(0, 1) == 1);
         if (k == 200) begin
            #2 rst = 1'b0;
            #1;
            chk("mid_rst_addr", imem_addr, 32'h100);
            chk("mid_rst_pc_o", pc_o, 32'h0);
            chk("mid_rst_inst", inst_o, NOP_INST);
            chk("mid_rst_pred", 32'(pred_o), 32'h0);
            tick();
            rst = 1'b1;
            model_reset();
         end
         @(negedge clk);
         chk("rnd_addr", imem_addr, m_pc);
         chk("rnd_pc_o", pc_o, m_pco);
         chk("rnd_inst", inst_o, m_inst);
         chk("rnd_pred", 32'(pred_o), 32'(m_pred));
         model_step();
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
